uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Frame sequencer for the UART transmit path. Sequences the Serializer, generates start/parity/stop bits
//  and muxes them with ser_data onto TX_OUT. Sits between the byte source (Data_Valid/P_DATA) and the line.
//  Owns Busy; the Serializer receives this block's Busy and ser_en.
// PARAMETERS
//  IN_WIDTH   8   data bits per frame; must match the Serializer's IN_WIDTH
// PORTS
//  CLK         in   1         single clock, all state on rising edge
//  RST         in   1         asynchronous, active-low reset
//  P_DATA      in   IN_WIDTH  parallel byte; sampled only when accepted
//  Data_Valid  in   1         request; accepted in IDLE or STOP (see below)
//  PAR_EN      in   1         1 = parity bit in frame; sampled with P_DATA
//  PAR_TYP     in   1         0 = even, 1 = odd; sampled with P_DATA
//  ser_data    in   1         current bit from Serializer (LSB first)
//  ser_done    in   1         Serializer: ser_data is the last data bit
//  ser_en      out  1         Enable to Serializer; high only in DATA
//  TX_OUT      out  1         serial line, idle high
//  Busy        out  1         frame in progress; registered
//  frame_err   out  1         one-cycle pulse on ser_done protocol violation
// BEHAVIOUR
//  - Reset (async, RST=0): state=IDLE, TX_OUT=1, Busy=0, ser_en=0, frame_err=0, bit_cnt=0. Effective
//    immediately, including mid-frame; the line returns to idle high, and the partial frame is abandoned.
//  - FSM states: IDLE, START, DATA, PARITY, STOP. One bit per CLK, no baud prescaler.
//  - TX_OUT = combinational mux of registered state: IDLE/STOP -> 1, START -> 0, DATA -> ser_data,
//    PARITY -> par_bit.
//  - IDLE: if Data_Valid at posedge -> START. Latch P_DATA, PAR_EN, PAR_TYP into par_bit logic at the same
//    edge. Busy goes 1 at that edge.
//  - START: one cycle -> DATA. bit_cnt cleared.
//  - DATA: ser_en=1, bit_cnt increments each cycle.
//    - ser_done=1 with bit_cnt==IN_WIDTH-1: -> PARITY if latched PAR_EN, else STOP.
//    - ser_done=1 early (bit_cnt<IN_WIDTH-1), or ser_done still 0 at bit_cnt==IN_WIDTH-1: pulse
//      frame_err and proceed exactly as a normal exit (bit_cnt governs). Frame length is never altered.
//  - PARITY: one cycle; par_bit = ^latched_data XOR PAR_TYP -> STOP.
//  - STOP: one cycle, TX_OUT=1.
//    - If Data_Valid: accept new byte (latch as in IDLE) -> START, Busy stays 1 (back-to-back, no gap).
//    - Else -> IDLE, Busy=0 from that edge.
//  - Data_Valid in START/DATA/PARITY is ignored (not queued). P_DATA changes mid-frame have no effect.
//  - Frame length: 1 + IN_WIDTH + PAR_EN + 1 cycles. Latency Data_Valid edge -> start bit on TX_OUT: 1 cycle.
//  - bit_cnt width = $clog2(IN_WIDTH); saturates, never wraps within DATA.
//  - PAR_EN/PAR_TYP toggling mid-frame: no effect; only latched copies are used.
// STRUCTURE
//  - Shared package uart_pkg: state encoding (3-bit localparams IDLE..STOP), mux-select codes (SEL_IDLE,
//    SEL_START, SEL_DATA, SEL_PAR), PARITY_EVEN/ODD constants.
//  - One sub-module: uart_parity_calc (IN_WIDTH data, PAR_TYP -> par_bit, with load enable register).
//  - FSM, bit counter, and output mux stay in uart_tx_ctrl.
// TESTING
//  1. 0xA5, PAR_EN=1, even:
//     TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles); Busy high for 11 cycles then 0.
//  2. 0xA5, PAR_EN=1, odd: same frame, parity bit = 1; frame_err never asserted.
//  3. 0x0F, PAR_EN=0: TX_OUT = 0,1,1,1,1,0,0,0,0,1 (10 cycles); ser_en high exactly 8 cycles.
//  4. Data_Valid held high with 0x55 then 0x33 accepted in STOP:
//     two frames with no idle bit between them; Busy never drops.
//  5. Data_Valid pulsed with 0xFF during DATA of a 0x00 frame:
//     ignored; 0x00 frame unaltered; IDLE follows.
//  6. RST low during bit 4 of DATA: TX_OUT=1, Busy=0, ser_en=0 immediately.
//     After release plus Data_Valid, a clean frame is sent.
//     Extra: force ser_done early at bit 2 -> frame_err pulse, frame length still 11.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: FSM states, line-mux selects, parity types.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic [1:0] SEL_IDLE  = 2'd0;
    localparam logic [1:0] SEL_START = 2'd1;
    localparam logic [1:0] SEL_DATA  = 2'd2;
    localparam logic [1:0] SEL_PAR   = 2'd3;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for one frame, computed and held when the byte is accepted.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [IN_WIDTH-1:0] data_i,
    input  logic                par_typ_i,
    output logic                par_bit_o
);

    logic par_bit_q;
    logic par_bit_d;

    // Even parity is the plain XOR reduction; odd inverts it.
    always_comb begin
        par_bit_d = par_bit_q;
        if (load_i) begin
            par_bit_d = (^data_i) ^ (par_typ_i == PARITY_ODD);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_bit_q <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
        end
    end

    assign par_bit_o = par_bit_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start/data/parity/stop framing, Serializer enable and line mux.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IN_WIDTH-1:0] P_DATA,
    input  logic                Data_Valid,
    input  logic                PAR_EN,
    input  logic                PAR_TYP,
    input  logic                ser_data,
    input  logic                ser_done,
    output logic                ser_en,
    output logic                TX_OUT,
    output logic                Busy,
    output logic                frame_err
);

    localparam int unsigned    CNT_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             ferr_q, ferr_d;
    logic             par_en_q, par_en_d;
    logic             accept_c;
    logic             ser_en_c;
    logic [1:0]       sel_c;
    logic             par_bit;

    uart_parity_calc #(
        .IN_WIDTH (IN_WIDTH)
    ) u_parity (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .load_i    (accept_c),
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .par_bit_o (par_bit)
    );

    // Next state; bit_cnt alone decides the end of DATA, ser_done only flags disagreement.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        ferr_d    = 1'b0;
        accept_c  = 1'b0;
        ser_en_c  = 1'b0;
        sel_c     = SEL_IDLE;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    accept_c = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                sel_c     = SEL_START;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                sel_c    = SEL_DATA;
                ser_en_c = 1'b1;
                if (bit_cnt_q == CNT_LAST) begin
                    ferr_d  = !ser_done;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    ferr_d    = ser_done;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                sel_c   = SEL_PAR;
                state_d = STOP;
            end
            STOP: begin
                if (Data_Valid) begin
                    accept_c = 1'b1;
                    state_d  = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept_c) begin
            par_en_d = PAR_EN;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            ferr_q    <= ferr_d;
            par_en_q  <= par_en_d;
        end
    end

    // Line mux decoded from registered state only.
    always_comb begin
        TX_OUT = 1'b1;
        case (sel_c)
            SEL_START: TX_OUT = 1'b0;
            SEL_DATA:  TX_OUT = ser_data;
            SEL_PAR:   TX_OUT = par_bit;
            default:   TX_OUT = 1'b1;
        endcase
    end

    assign ser_en    = ser_en_c;
    assign Busy      = busy_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural Serializer model.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       TX_OUT;
    logic       Busy;
    logic       frame_err;

    typedef struct packed {
        logic tx;
        logic busy;
        logic sen;
        logic ferr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic running  = 1'b0;
    logic inj      = 1'b0;

    logic [7:0] sreg;
    int         scnt;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.IN_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .frame_err  (frame_err)
    );

    // Serializer model: loads P_DATA while idle, shifts LSB first while enabled.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sreg <= 8'h00;
            scnt <= 0;
        end else if (ser_en) begin
            sreg <= sreg >> 1;
            scnt <= scnt + 1;
        end else begin
            sreg <= P_DATA;
            scnt <= 0;
        end
    end

    assign ser_data = sreg[0];
    assign ser_done = ser_en && ((scnt == 7) || (inj && scnt == 2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input int err_at);
        exp_t e;
        e.tx = 1'b0; e.busy = 1'b1; e.sen = 1'b0; e.ferr = 1'b0;
        sb.push_back(e);
        for (int k = 0; k < 8; k++) begin
            e.tx   = d[k];
            e.sen  = 1'b1;
            e.ferr = (err_at >= 0) && (k == err_at + 1);
            sb.push_back(e);
        end
        e.sen  = 1'b0;
        e.ferr = 1'b0;
        if (pe) begin
            e.tx = (^d) ^ pt;
            sb.push_back(e);
        end
        e.tx = 1'b1;
        sb.push_back(e);
    endtask

    // Offer a byte for one cycle, then scramble the parity controls mid-frame.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int err_at);
        @(posedge CLK);
        #1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(posedge CLK);
        push_frame(d, pe, pt, err_at);
        #1;
        Data_Valid = 1'b0;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (running && RST) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
            end else begin
                e.tx = 1'b1; e.busy = 1'b0; e.sen = 1'b0; e.ferr = 1'b0;
            end
            check("tx_out",    32'(TX_OUT),    32'(e.tx));
            check("busy",      32'(Busy),      32'(e.busy));
            check("ser_en",    32'(ser_en),    32'(e.sen));
            check("frame_err", 32'(frame_err), 32'(e.ferr));
        end
    end

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        check("rst_tx",     32'(TX_OUT),    32'd1);
        check("rst_busy",   32'(Busy),      32'd0);
        check("rst_ser_en", 32'(ser_en),    32'd0);
        check("rst_ferr",   32'(frame_err), 32'd0);
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        running = 1'b1;

        send(8'hA5, 1'b1, 1'b0, -1);
        repeat (13) @(posedge CLK);
        send(8'hA5, 1'b1, 1'b1, -1);
        repeat (13) @(posedge CLK);
        send(8'h0F, 1'b0, 1'b0, -1);
        repeat (12) @(posedge CLK);

        // Back-to-back: Data_Valid held through the first frame, second byte taken in STOP.
        @(posedge CLK);
        #1;
        P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(posedge CLK);
        push_frame(8'h55, 1'b1, 1'b0, -1);
        repeat (10) @(posedge CLK);
        #1;
        P_DATA = 8'h33; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        @(posedge CLK);
        push_frame(8'h33, 1'b1, 1'b1, -1);
        #1;
        Data_Valid = 1'b0;
        repeat (13) @(posedge CLK);

        // Request during DATA is dropped.
        send(8'h00, 1'b0, 1'b0, -1);
        repeat (3) @(posedge CLK);
        #1;
        P_DATA = 8'hFF; Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        P_DATA = 8'h00; Data_Valid = 1'b0;
        repeat (11) @(posedge CLK);

        // Early ser_done at bit 2.
        inj = 1'b1;
        send(8'hA5, 1'b1, 1'b0, 2);
        repeat (13) @(posedge CLK);
        inj = 1'b0;

        // Reset mid-DATA, then a clean frame.
        send(8'hC3, 1'b1, 1'b0, -1);
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("midrst_tx",     32'(TX_OUT), 32'd1);
        check("midrst_busy",   32'(Busy),   32'd0);
        check("midrst_ser_en", 32'(ser_en), 32'd0);
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        send(8'h3C, 1'b1, 1'b1, -1);

        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge CLK);
        check("sb_drain", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
